// File: rtl/invert.sv
// Serial two's-complement negator. The operand arrives LSB first, one bit
// per t_clk cycle. Bits pass through unchanged up to and including the
// first 1, and every later bit is inverted. The result is registered, so
// it appears one cycle after the bit is sampled.
module invert (
  input  logic i,
  input  logic r,
  input  logic t_clk,
  output logic y
);

  // PASS: no 1 has been seen since reset; INV: a 1 has been seen.
  typedef enum logic [0:0] {
    PASS = 1'b0,
    INV  = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   y_reg;
  logic   y_next;

  // State and output registers. Reset takes priority over i, so the bit
  // sampled at a reset edge is dropped and cannot move the FSM to INV.
  always_ff @(posedge t_clk) begin
    if (r) begin
      state_reg <= PASS;
      y_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
    end
  end

  // Next state and next output bit, decided from the state before the edge.
  always_comb begin
    state_next = state_reg;
    y_next     = i;
    case (state_reg)
      PASS: begin
        // The first 1 is copied unchanged. It also arms the inversion
        // for every bit that follows.
        y_next = i;
        if (i) begin
          state_next = INV;
        end
      end
      INV: begin
        // This state holds until reset, whatever value i takes.
        y_next     = ~i;
        state_next = INV;
      end
      default: begin
        // An undefined encoding falls back to PASS at the next edge.
        y_next     = i;
        state_next = PASS;
      end
    endcase
  end

  // y comes only from the flop, so a change on i between edges cannot
  // reach the output.
  assign y = y_reg;

endmodule

// File: tb/tb_invert.sv
// Directed testbench for the serial two's-complement negator.
// Inputs are driven 1 ns after each rising edge. The output is sampled
// 1 ns after the edge that registers it.
module tb_invert;

  logic i;
  logic r;
  logic t_clk;
  logic y;

  int tests_run;
  int tests_failed;

  invert dut (
    .i     (i),
    .r     (r),
    .t_clk (t_clk),
    .y     (y)
  );

  // 180 ns clock period.
  initial begin
    t_clk = 1'b0;
    forever #90 t_clk = ~t_clk;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got y=%b required y=%b", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: y=%b", tag, obs);
    end
  endtask

  // Drive one bit (with reset level rv) and check y after the edge.
  task automatic apply(input logic rv, input logic iv, input logic exp, input string tag);
    r = rv;
    i = iv;
    @(posedge t_clk);
    #1;
    check(tag, y, exp);
  endtask

  // Drive a, switch i to b 66 ns after the edge, and confirm y holds
  // until the next edge. Then check that the edge registers the result
  // for b.
  task automatic mid(input logic a, input logic b, input logic prev, input logic exp, input string tag);
    r = 1'b0;
    i = a;
    #65;
    i = b;
    #100;
    check({tag, "_hold"}, y, prev);
    @(posedge t_clk);
    #1;
    check(tag, y, exp);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    r = 1'b1;
    i = 1'b1;
    @(posedge t_clk);
    #1;

    // Reset with i=1 gives y=0. The next bit, 0, must stay 0.
    apply(1'b1, 1'b1, 1'b0, "rst_i1");
    apply(1'b0, 1'b0, 1'b0, "rst_next0");

    // 0b011010 -> 0b100110, LSB first.
    apply(1'b1, 1'b0, 1'b0, "s1_rst");
    apply(1'b0, 1'b0, 1'b0, "s1_b0");
    apply(1'b0, 1'b1, 1'b1, "s1_b1");
    apply(1'b0, 1'b0, 1'b1, "s1_b2");
    apply(1'b0, 1'b1, 1'b0, "s1_b3");
    apply(1'b0, 1'b1, 1'b0, "s1_b4");
    apply(1'b0, 1'b0, 1'b1, "s1_b5");

    // An all-zero stream gives all zeros.
    apply(1'b1, 1'b0, 1'b0, "z_rst");
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 1'b0, $sformatf("z_b%0d", k));
    end

    // -1 -> 1 in 4 bits.
    apply(1'b1, 1'b0, 1'b0, "m1_rst");
    apply(1'b0, 1'b1, 1'b1, "m1_b0");
    apply(1'b0, 1'b1, 1'b0, "m1_b1");
    apply(1'b0, 1'b1, 1'b0, "m1_b2");
    apply(1'b0, 1'b1, 1'b0, "m1_b3");

    // Reset mid-stream clears INV, and the bit at the reset edge is ignored.
    apply(1'b1, 1'b0, 1'b0, "mr_rst0");
    apply(1'b0, 1'b0, 1'b0, "mr_b0");
    apply(1'b0, 1'b1, 1'b1, "mr_b1");
    apply(1'b0, 1'b1, 1'b0, "mr_b2");
    apply(1'b1, 1'b1, 1'b0, "mr_rst1");
    apply(1'b0, 1'b1, 1'b1, "mr_n0");
    apply(1'b0, 1'b0, 1'b1, "mr_n1");

    // Reset held for 3 edges from INV with i=1. y stays 0 and the state
    // returns to PASS.
    apply(1'b1, 1'b1, 1'b0, "hold_r0");
    apply(1'b1, 1'b1, 1'b0, "hold_r1");
    apply(1'b1, 1'b1, 1'b0, "hold_r2");
    apply(1'b0, 1'b0, 1'b0, "hold_b0");
    apply(1'b0, 1'b1, 1'b1, "hold_b1");
    apply(1'b0, 1'b1, 1'b0, "hold_b2");

    // i toggled mid-cycle. The sampled bits are 0,1,0,0,1, so the
    // expected y is 0,1,1,1,0.
    apply(1'b1, 1'b0, 1'b0, "mc_rst");
    mid(1'b1, 1'b0, 1'b0, 1'b0, "mc_b0");
    mid(1'b0, 1'b1, 1'b0, 1'b1, "mc_b1");
    mid(1'b1, 1'b0, 1'b1, 1'b1, "mc_b2");
    mid(1'b1, 1'b0, 1'b1, 1'b1, "mc_b3");
    mid(1'b0, 1'b1, 1'b1, 1'b0, "mc_b4");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/invert.md
INVERT -- requirements
Module: invert

Interface
REQ-001 The block SHALL have no parameters; the datapath is a fixed 1-bit serial stream.
REQ-002 t_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 r  input  1  reset, synchronous and active-high; sampled on the rising edge of t_clk.
REQ-004 i  input  1  serial operand bit, LSB first, one bit per t_clk cycle.
REQ-005 y  output  1  serial two's-complement result bit, LSB first, registered.
REQ-006 Port order at instantiation SHALL be (i, r, t_clk, y).

Function
REQ-007 The block SHALL compute the serial two's complement (negation) of the bit stream on i, LSB first.
REQ-008 Algorithm: pass bits unchanged up to and including the first 1, then invert every later bit.
REQ-009 The FSM SHALL have two states: PASS (no 1 seen yet) and INV (a 1 has been seen).
REQ-010 PASS -> INV on a rising edge with r=0 and i=1; PASS -> PASS on i=0.
REQ-011 INV SHALL persist for every value of i until reset.
REQ-012 On each rising edge with r=0: y <= i if the state is PASS before the edge; y <= ~i if the state is INV before the edge.
REQ-013 Latency SHALL be one t_clk cycle: y after edge n equals the result for the bit sampled at edge n.
REQ-014 y SHALL be driven only from a flip-flop, with no combinational path from i to y, so asynchronous changes on i SHALL NOT glitch y.
REQ-015 i SHALL be sampled only at rising edges; changes between edges SHALL have no effect.
REQ-016 The first 1 bit SHALL appear on y unchanged (1), because the state before that edge is PASS.
REQ-017 An all-zero stream SHALL produce an all-zero y, since -0 = 0.
REQ-018 Word boundaries are not tracked; a new operand SHALL start only after asserting r for at least one edge.
REQ-019 State encoding is free; unused encodings, if any, SHALL recover to PASS on the next edge.
REQ-020 Before the first reset edge, y and the state are unspecified (X allowed).

Reset
REQ-021 A rising edge with r=1 SHALL force state=PASS and y=0, regardless of i.
REQ-022 r has priority over i at the same edge; the bit sampled at a reset edge SHALL be discarded and SHALL NOT set INV.
REQ-023 Reset asserted in INV mid-stream SHALL return the block to PASS at that edge; the first edge after r falls SHALL be treated as bit 0 of a new word.
REQ-024 Holding r=1 for several cycles SHALL keep y=0 and state=PASS.

Verification
REQ-025 r=1 for 1 edge with i=1 -> y=0 and state PASS; next edge with r=0 and i=0 -> y=0.
REQ-026 After reset, LSB-first i = 0,1,0,1,1,0 -> y = 0,1,1,0,0,1 (0b011010 -> 0b100110), each bit one edge later.
REQ-027 After reset, i=0 for 8 edges -> y=0 for all 8.
REQ-028 After reset, i = 1,1,1,1 -> y = 1,0,0,0 (-1 -> 1 in 4 bits).
REQ-029 Stream 0,1,1 then r=1 with i=1, then r=0 with i=1,0 -> y = 0,1,0 | 0 | 1,1 (INV cleared; the bit at the reset edge is ignored).
REQ-030 i toggled mid-cycle (about 66 ns after an edge, 180 ns period) -> y changes only at rising edges and matches the bit sampled at each edge.
